// File: rtl/lsl_seq_if.sv
// rtl/lsl_seq_if.sv - handshake bundle for the sequential shift-left unit (carry signal present only with LSL_CARRY_EN)
interface lsl_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic [SHW-1:0]   sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
`ifdef LSL_CARRY_EN
  logic             carry;
`endif

`ifdef LSL_CARRY_EN
  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, d, sel, out_ready,
    input  in_ready, out_valid, z, carry
  );
  // Shift unit side.
  modport slave (
    input  in_valid, d, sel, out_ready,
    output in_ready, out_valid, z, carry
  );
`else
  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, d, sel, out_ready,
    input  in_ready, out_valid, z
  );
  // Shift unit side.
  modport slave (
    input  in_valid, d, sel, out_ready,
    output in_ready, out_valid, z
  );
`endif
endinterface

// File: rtl/lsl_seq.sv
// rtl/lsl_seq.sv - multi-cycle logical shift-left, one barrel stage per clock; optional carry output under LSL_CARRY_EN
module lsl_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic      clk,
  input  logic      reset,
  lsl_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  // Remaining shift-amount bits; bit 0 always belongs to the current stage.
  logic [SHW-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  // Stage shift distance 2^cnt; largest value WIDTH/2 fits in SHW bits.
  logic [SHW-1:0]   k_amt;
  logic [WIDTH-1:0] acc_shl;
  logic             last_stage;

`ifdef LSL_CARRY_EN
  logic             carry_q, carry_d;
  // One extra bit above the accumulator catches acc[WIDTH-k], the last bit pushed out.
  logic [WIDTH:0]   acc_wide;
`endif

  // Datapath for the current stage plus next-state logic for every register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sel_d       = sel_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    k_amt       = SHW'(1) << cnt_q;
    last_stage  = (cnt_q == SHW'(SHW - 1));
`ifdef LSL_CARRY_EN
    carry_d     = carry_q;
    acc_wide    = {1'b0, acc_q} << k_amt;
    acc_shl     = acc_wide[WIDTH-1:0];
`else
    acc_shl     = acc_q << k_amt;
`endif

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) begin
          acc_d      = bus.d;
          sel_d      = bus.sel;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_SHIFT;
`ifdef LSL_CARRY_EN
          carry_d    = 1'b0;
`endif
        end
      end

      S_SHIFT: begin
        if (sel_q[0]) begin
          acc_d   = acc_shl;
`ifdef LSL_CARRY_EN
          carry_d = acc_wide[WIDTH];
`endif
        end
        sel_d = sel_q >> 1;
        if (last_stage) begin
          // cnt parks at SHW-1; the next acceptance clears it.
          z_d         = sel_q[0] ? acc_shl : acc_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + SHW'(1);
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sel_q       <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef LSL_CARRY_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sel_q       <= sel_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef LSL_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
`ifdef LSL_CARRY_EN
  assign bus.carry     = carry_q;
`endif

endmodule

// File: tb/tb_lsl_seq.sv
// tb/tb_lsl_seq.sv - self-checking bench for lsl_seq against a shift-arithmetic reference (carry checked with LSL_CARRY_EN)
module tb_lsl_seq;
  localparam int W = 32;
  localparam int S = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  lsl_seq_if #(.WIDTH(W), .SHW(S)) bus ();

  lsl_seq #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1);
  end

  // Reference: zero-filled left shift; carry is the bit landing just above the MSB.
  function automatic logic [31:0] ref_z(input logic [31:0] dv, input int sv);
    return dv << sv;
  endfunction

  function automatic logic ref_c(input logic [31:0] dv, input int sv);
    logic [63:0] w;
    w = {32'd0, dv} << sv;
    return w[32];
  endfunction

  function automatic logic dut_carry();
`ifdef LSL_CARRY_EN
    return bus.carry;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation from a negedge; returns result, latency and handshake observations.
  task automatic run_op(input logic [31:0] dv, input logic [4:0] sv, input int hold,
                        output logic [31:0] zv, output logic cv, output int lat,
                        output logic stable_ok, output logic post_ok);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required=1", bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.d         = dv;
    bus.sel       = sv;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.d        = $urandom;
    bus.sel      = 5'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    zv = bus.z;
    cv = dut_carry();
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.z !== zv || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    post_ok = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.d         = '0;
    bus.sel       = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z !== 32'h0 || dut_carry() !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b z=%h carry=%0b required=1 0 00000000 0",
               bus.in_ready, bus.out_valid, bus.z, dut_carry());
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] dt [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1234_5678};
    int          st [4] = '{31, 4, 1, 0};
    logic [31:0] zt [4] = '{32'h8000_0000, 32'hFFFF_FFF0, 32'h0000_0002, 32'h1234_5678};
    logic        ct [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] zv;
    logic        cv, st_ok, po_ok;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(dt[i], 5'(st[i]), 0, zv, cv, lat, st_ok, po_ok);
      checks++;
      if (zv !== zt[i]) begin
        errors++;
        $display("FAIL directed_z[%0d]: z=%h required=%h", i, zv, zt[i]);
      end
      checks++;
      if (lat !== S) begin
        errors++;
        $display("FAIL directed_latency[%0d]: edges=%0d required=%0d", i, lat, S);
      end
`ifdef LSL_CARRY_EN
      checks++;
      if (cv !== ct[i]) begin
        errors++;
        $display("FAIL directed_carry[%0d]: carry=%0b required=%0b", i, cv, ct[i]);
      end
`endif
      checks++;
      if (!po_ok) begin
        errors++;
        $display("FAIL directed_release[%0d]: out_valid=%0b in_ready=%0b required=0 1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] dv, zh;
    int          sv, t;
    dv = $urandom;
    sv = $urandom_range(1, 31);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.d         = dv;
    bus.sel       = 5'(sv);
    @(posedge clk);
    @(negedge clk);
    // Keep offering a bogus operand while the unit is busy shifting.
    bus.d = 32'hDEAD_BEEF;
    bus.sel = 5'd3;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    zh = bus.z;
    checks++;
    if (zh !== ref_z(dv, sv) || t !== S) begin
      errors++;
      $display("FAIL bp_result: z=%h edges=%0d required=%h %0d", zh, t, ref_z(dv, sv), S);
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i != 1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.z !== zh || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b z=%h in_ready=%0b required=1 %h 0",
                 i, bus.out_valid, bus.z, bus.in_ready, zh);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required=0 1", bus.out_valid, bus.in_ready);
    end
    t = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) t++;
    end
    checks++;
    if (t != 0) begin
      errors++;
      $display("FAIL bp_no_ghost_op: bad_cycles=%0d required=0", t);
    end
  endtask

  task automatic test_random();
    logic [31:0] dv, zv;
    logic        cv, st_ok, po_ok;
    int          sv, lat, bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      dv = $urandom;
      sv = $urandom_range(0, 31);
      run_op(dv, 5'(sv), $urandom_range(0, 3), zv, cv, lat, st_ok, po_ok);
      checks++;
      if (zv !== ref_z(dv, sv) || lat !== S || !st_ok || !po_ok) begin
        errors++;
        $display("FAIL random[%0d]: d=%h sel=%0d z=%h edges=%0d stable=%0b release=%0b required=%h %0d 1 1",
                 i, dv, sv, zv, lat, st_ok, po_ok, ref_z(dv, sv), S);
      end
`ifdef LSL_CARRY_EN
      checks++;
      if (cv !== ref_c(dv, sv)) begin
        errors++;
        $display("FAIL random_carry[%0d]: d=%h sel=%0d carry=%0b required=%0b", i, dv, sv, cv, ref_c(dv, sv));
      end
`endif
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] zv;
    logic        cv, st_ok, po_ok;
    int          lat;
    run_op(32'h0000_0001, 5'd31, 0, zv, cv, lat, st_ok, po_ok);
    bus.in_valid = 1'b1;
    bus.d        = 32'hFFFF_FFFF;
    bus.sel      = 5'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.z !== 32'h0 || bus.in_ready !== 1'b1 || dut_carry() !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%0b z=%h in_ready=%0b carry=%0b required=0 00000000 1 0",
               bus.out_valid, bus.z, bus.in_ready, dut_carry());
    end
    reset = 1'b0;
    @(negedge clk);
    run_op(32'h0000_0003, 5'd8, 0, zv, cv, lat, st_ok, po_ok);
    checks++;
    if (zv !== 32'h0000_0300 || lat !== S || !po_ok) begin
      errors++;
      $display("FAIL post_reset_op: z=%h edges=%0d release=%0b required=00000300 %0d 1", zv, lat, po_ok, S);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int acc_cyc[32];
    int got, guard, bad_tp, mism;
    bus.out_ready = 1'b1;
    got  = 0;
    mism = 0;
    fork
      begin
        for (int s = 0; s < 32; s++) begin
          int t;
          t = 0;
          while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
          end
          bus.in_valid = 1'b1;
          bus.d        = 32'hA5A5_A5A5;
          bus.sel      = 5'(s);
          exp_q.push_back(s);
          @(posedge clk);
          @(negedge clk);
          acc_cyc[s]   = cyc;
          bus.in_valid = 1'b0;
          bus.d        = $urandom;
        end
      end
      begin
        guard = 0;
        while (got < 32 && guard < 600) begin
          @(negedge clk);
          guard++;
          if (bus.out_valid) begin
            int s;
            if (exp_q.size() == 0) begin
              mism++;
              $display("FAIL sweep_duplicate: unexpected result z=%h required=none", bus.z);
            end else begin
              s = exp_q.pop_front();
              if (bus.z !== ref_z(32'hA5A5_A5A5, s)) begin
                mism++;
                $display("FAIL sweep_z[%0d]: z=%h required=%h", s, bus.z, ref_z(32'hA5A5_A5A5, s));
              end
`ifdef LSL_CARRY_EN
              if (dut_carry() !== ref_c(32'hA5A5_A5A5, s)) begin
                mism++;
                $display("FAIL sweep_carry[%0d]: carry=%0b required=%0b", s, dut_carry(), ref_c(32'hA5A5_A5A5, s));
              end
`endif
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL sweep_results: mismatches=%0d required=0", mism);
    end
    checks++;
    if (got != 32 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_count: results=%0d pending=%0d required=32 0", got, exp_q.size());
    end
    bad_tp = 0;
    for (int s = 1; s < 32; s++) if (acc_cyc[s] - acc_cyc[s-1] != S + 2) bad_tp++;
    checks++;
    if (bad_tp != 0) begin
      errors++;
      $display("FAIL sweep_throughput: bad_spacings=%0d required=0 (period %0d)", bad_tp, S + 2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
